// File: rtl/sdm_stream_controller.sv
// Sample FIFO, sequencer and bit packer for the sigma-delta modulator datapath.
// Define SDM_CTRL_STATS_EN to add the per-sample-period ones counter (ones_count_o/ones_valid_o).
module sdm_stream_controller #(
    parameter int unsigned Depth    = 8,
    parameter int unsigned Osr      = 64,
    parameter int unsigned ClearCyc = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic [15:0]            s_data_i,
    output logic [$clog2(Depth):0] fill_o,
    output logic [15:0]            mod_dataword_o,
    output logic                   mod_clear_n_o,
    input  logic                   mod_bit_i,
    output logic [7:0]             bits_out_o,
    output logic                   bits_valid_o,
    output logic                   busy_o,
`ifdef SDM_CTRL_STATS_EN
    output logic [$clog2(Osr):0]   ones_count_o,
    output logic                   ones_valid_o,
`endif
    output logic                   underflow_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned FW = AW + 1;
    localparam int unsigned SW = $clog2(Osr);
    localparam int unsigned CW = (ClearCyc > 1) ? $clog2(ClearCyc) : 1;

    localparam logic [FW-1:0] FillFull = FW'(Depth);
    localparam logic [SW-1:0] SlotLast = SW'(Osr - 1);
    localparam logic [CW-1:0] ClrLast  = CW'(ClearCyc - 1);

    typedef enum logic [1:0] {StIdle, StClear, StRun} state_e;

    state_e          state_q, state_d;
    logic [15:0]     mem [Depth];
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic [CW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [15:0]     dword_q, dword_d;
    logic            underflow_q, underflow_d;
    logic [6:0]      pack_q, pack_d;
    logic [7:0]      bits_out_q, bits_out_d;
    logic            bits_valid_q, bits_valid_d;
    logic            push, pop, pop_req;

    // READY comes from the pre-edge fill, so a same-cycle pop never frees a slot for a push.
    assign push = s_valid_i && (fill_q != FillFull);
    assign pop  = pop_req && (fill_q != '0);

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        slot_d      = slot_q;
        dword_d     = dword_q;
        underflow_d = underflow_q;
        pop_req     = 1'b0;

        unique case (state_q)
            StIdle: begin
                clr_cnt_d = '0;
                slot_d    = '0;
                dword_d   = '0;
                if (enable_i && (fill_q != '0)) begin
                    state_d     = StClear;
                    underflow_d = 1'b0;
                end
            end
            StClear: begin
                if (!enable_i) begin
                    state_d   = StIdle;
                    clr_cnt_d = '0;
                end else if (clr_cnt_q == ClrLast) begin
                    state_d   = StRun;
                    clr_cnt_d = '0;
                    slot_d    = '0;
                    pop_req   = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + CW'(1);
                end
            end
            StRun: begin
                if (!enable_i) begin
                    state_d = StIdle;
                    slot_d  = '0;
                    dword_d = '0;
                end else if (slot_q == SlotLast) begin
                    slot_d  = '0;
                    pop_req = 1'b1;
                end else begin
                    slot_d = slot_q + SW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (pop_req) begin
            if (fill_q != '0) begin
                dword_d = mem[rptr_q];
            end else begin
                dword_d     = '0;
                underflow_d = 1'b1;
            end
        end
    end

    always_comb begin
        wptr_d = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d = pop ? rptr_q + AW'(1) : rptr_q;
        unique case ({push, pop})
            2'b10:   fill_d = fill_q + FW'(1);
            2'b01:   fill_d = fill_q - FW'(1);
            default: fill_d = fill_q;
        endcase
    end

    // Slot counter low bits double as the bit index: bytes start on slot 0 since Osr % 8 == 0.
    always_comb begin
        pack_d       = pack_q;
        bits_out_d   = bits_out_q;
        bits_valid_d = 1'b0;
        if (state_q == StRun) begin
            pack_d = {mod_bit_i, pack_q[6:1]};
            if (slot_q[2:0] == 3'd7) begin
                bits_out_d   = {mod_bit_i, pack_q};
                bits_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wptr_q] <= s_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            wptr_q       <= '0;
            rptr_q       <= '0;
            fill_q       <= '0;
            clr_cnt_q    <= '0;
            slot_q       <= '0;
            dword_q      <= '0;
            underflow_q  <= 1'b0;
            pack_q       <= '0;
            bits_out_q   <= '0;
            bits_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            fill_q       <= fill_d;
            clr_cnt_q    <= clr_cnt_d;
            slot_q       <= slot_d;
            dword_q      <= dword_d;
            underflow_q  <= underflow_d;
            pack_q       <= pack_d;
            bits_out_q   <= bits_out_d;
            bits_valid_q <= bits_valid_d;
        end
    end

`ifdef SDM_CTRL_STATS_EN
    logic [SW:0] ones_acc_q, ones_acc_d, ones_count_q, ones_count_d;
    logic        ones_valid_q, ones_valid_d;

    always_comb begin
        ones_acc_d   = '0;
        ones_count_d = ones_count_q;
        ones_valid_d = 1'b0;
        if (state_q == StRun) begin
            if (slot_q == SlotLast) begin
                ones_count_d = ones_acc_q + (SW+1)'(mod_bit_i);
                ones_valid_d = 1'b1;
            end else begin
                ones_acc_d = ones_acc_q + (SW+1)'(mod_bit_i);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ones_acc_q   <= '0;
            ones_count_q <= '0;
            ones_valid_q <= 1'b0;
        end else begin
            ones_acc_q   <= ones_acc_d;
            ones_count_q <= ones_count_d;
            ones_valid_q <= ones_valid_d;
        end
    end

    assign ones_count_o = ones_count_q;
    assign ones_valid_o = ones_valid_q;
`endif

    assign s_ready_o      = (fill_q != FillFull);
    assign fill_o         = fill_q;
    assign mod_dataword_o = dword_q;
    assign mod_clear_n_o  = (state_q == StRun);
    assign bits_out_o     = bits_out_q;
    assign bits_valid_o   = bits_valid_q;
    assign busy_o         = (state_q != StIdle);
    assign underflow_o    = underflow_q;

endmodule
